// File: rtl/ysyx_22041207_cache_refill.sv
// Miss/refill and write-through controller sitting between the core load/store
// port, the 2-way data cache and the memory bus.
module ysyx_22041207_cache_refill #(
    parameter logic [63:0] UNCACHED_BASE = 64'h0000_0000_a000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic [63:0] cache_raddr,
    input  logic        cache_hit,
    input  logic [63:0] cache_rdata,
    output logic        cache_upd_valid,
    output logic [63:0] cache_upd_addr,
    output logic [63:0] cache_upd_data,
    output logic        cache_wupd_valid,
    output logic [63:0] cache_wupd_addr,
    output logic [63:0] cache_wupd_data,
    output logic [7:0]  cache_wupd_mask,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_write,
    output logic [63:0] mem_req_addr,
    output logic [63:0] mem_req_wdata,
    output logic [7:0]  mem_req_wmask,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_rdata,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, RD_DONE, WR_REQ, WR_WAIT
    } state_t;

    state_t      state, state_nxt;
    logic        accept, req_cached, load_hit;
    logic [63:0] addr_q, wdata_q, rdata_q;
    logic [7:0]  wmask_q;
    logic        cached_q, wr_first_q;

    function automatic logic [63:0] align8(input logic [63:0] a);
        return {a[63:3], 3'b000};
    endfunction

    assign accept     = req_valid && req_ready;
    assign req_cached = (req_addr < UNCACHED_BASE);
    assign load_hit   = !req_write && req_cached && cache_hit;

    assign cache_raddr     = req_addr;
    assign mem_req_addr    = align8(addr_q);
    assign mem_req_wdata   = wdata_q;
    assign mem_req_wmask   = wmask_q;
    assign cache_upd_addr  = align8(addr_q);
    assign cache_upd_data  = rdata_q;
    assign cache_wupd_addr = addr_q;
    assign cache_wupd_data = wdata_q;
    assign cache_wupd_mask = wmask_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_write)      state_nxt = WR_REQ;
                    else if (!load_hit) state_nxt = RD_REQ;
                end
            end
            RD_REQ:  if (mem_req_ready)  state_nxt = RD_WAIT;
            RD_WAIT: if (mem_resp_valid) state_nxt = RD_DONE;
            RD_DONE: state_nxt = IDLE;
            WR_REQ:  if (mem_req_ready)  state_nxt = WR_WAIT;
            WR_WAIT: if (mem_resp_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake strobes are pure decodes of the state, so an async reset
    // clears them in the same instant it forces IDLE.
    always_comb begin
        req_ready        = 1'b0;
        mem_req_valid    = 1'b0;
        mem_req_write    = 1'b0;
        cache_upd_valid  = 1'b0;
        cache_wupd_valid = 1'b0;
        case (state)
            IDLE:    req_ready = !rst;
            RD_REQ:  mem_req_valid = 1'b1;
            RD_DONE: cache_upd_valid = cached_q;
            WR_REQ: begin
                mem_req_valid    = 1'b1;
                mem_req_write    = 1'b1;
                cache_wupd_valid = wr_first_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            rdata_q    <= '0;
            cached_q   <= 1'b0;
            wr_first_q <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            resp_valid <= 1'b0;
            if (state == WR_REQ) wr_first_q <= 1'b0;
            if (accept) begin
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                wmask_q    <= req_wmask;
                cached_q   <= req_cached;
                wr_first_q <= req_write && req_cached;
                if (load_hit) begin
                    resp_valid <= 1'b1;
                    resp_rdata <= cache_rdata;
                    hit_count  <= hit_count + 32'd1;
                end else if (!req_write && req_cached) begin
                    miss_count <= miss_count + 32'd1;
                end
            end
            // Responses only count while a transaction is waiting for them.
            if (state == RD_WAIT && mem_resp_valid) begin
                rdata_q    <= mem_resp_rdata;
                resp_valid <= 1'b1;
                resp_rdata <= mem_resp_rdata;
            end
            if (state == WR_WAIT && mem_resp_valid) begin
                resp_valid <= 1'b1;
                resp_rdata <= '0;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_22041207_cache_refill.sv
// Directed plus randomized bench for the cache refill / write-through controller.
module tb_ysyx_22041207_cache_refill;
    localparam logic [63:0] UNC = 64'h0000_0000_a000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [63:0] req_addr, req_wdata;
    logic [7:0]  req_wmask;
    logic        resp_valid;
    logic [63:0] resp_rdata, cache_raddr;
    logic        cache_hit;
    logic [63:0] cache_rdata;
    logic        cache_upd_valid;
    logic [63:0] cache_upd_addr, cache_upd_data;
    logic        cache_wupd_valid;
    logic [63:0] cache_wupd_addr, cache_wupd_data;
    logic [7:0]  cache_wupd_mask;
    logic        mem_req_valid, mem_req_ready, mem_req_write;
    logic [63:0] mem_req_addr, mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;
    logic [31:0] hit_count, miss_count;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_hits, exp_miss;

    always #5 clk = ~clk;

    ysyx_22041207_cache_refill #(.UNCACHED_BASE(UNC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .cache_raddr(cache_raddr), .cache_hit(cache_hit), .cache_rdata(cache_rdata),
        .cache_upd_valid(cache_upd_valid), .cache_upd_addr(cache_upd_addr),
        .cache_upd_data(cache_upd_data),
        .cache_wupd_valid(cache_wupd_valid), .cache_wupd_addr(cache_wupd_addr),
        .cache_wupd_data(cache_wupd_data), .cache_wupd_mask(cache_wupd_mask),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_counters();
        chk("hit_count", 64'(hit_count), 64'(exp_hits));
        chk("miss_count", 64'(miss_count), 64'(exp_miss));
    endtask

    // Load: hit returns next cycle; miss/uncached goes through memory.
    task automatic do_load(input logic [63:0] a, input logic hit, input logic [63:0] cd,
                           input int rdly, input int sdly, input logic [63:0] md);
        logic cached;
        cached = (a < UNC);
        chk("ld_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_write = 1'b0; req_addr = a;
        cache_hit = hit; cache_rdata = cd;
        chk("ld_raddr", cache_raddr, a);
        tick();
        req_valid = 1'b0; cache_hit = 1'b0;
        if (cached && hit) begin
            exp_hits = exp_hits + 32'd1;
            chk("hit_resp_valid", 64'(resp_valid), 64'd1);
            chk("hit_resp_rdata", resp_rdata, cd);
            chk("hit_no_mem", 64'(mem_req_valid), 64'd0);
        end else begin
            if (cached) exp_miss = exp_miss + 32'd1;
            for (int i = 0; i <= rdly; i++) begin
                chk("rd_req_valid", 64'(mem_req_valid), 64'd1);
                chk("rd_req_write", 64'(mem_req_write), 64'd0);
                chk("rd_req_addr", mem_req_addr, {a[63:3], 3'b000});
                chk("rd_no_resp", 64'(resp_valid), 64'd0);
                if (i == rdly) mem_req_ready = 1'b1;
                tick();
            end
            mem_req_ready = 1'b0;
            for (int i = 0; i < sdly; i++) begin
                chk("rd_wait_idle", 64'({mem_req_valid, resp_valid, cache_upd_valid}), 64'd0);
                tick();
            end
            mem_resp_valid = 1'b1; mem_resp_rdata = md;
            tick();
            mem_resp_valid = 1'b0; mem_resp_rdata = '0;
            chk("rd_done_resp_valid", 64'(resp_valid), 64'd1);
            chk("rd_done_resp_rdata", resp_rdata, md);
            chk("rd_done_upd_valid", 64'(cache_upd_valid), 64'(cached));
            chk("rd_done_no_wupd", 64'(cache_wupd_valid), 64'd0);
            if (cached) begin
                chk("rd_done_upd_addr", cache_upd_addr, {a[63:3], 3'b000});
                chk("rd_done_upd_data", cache_upd_data, md);
            end
            tick();
            chk("rd_after_quiet", 64'({resp_valid, cache_upd_valid, mem_req_valid}), 64'd0);
        end
        chk_counters();
    endtask

    // Store: invalidate pulse in first WR_REQ cycle (cached only), write-through, ack.
    task automatic do_store(input logic [63:0] a, input logic [63:0] wd, input logic [7:0] wm,
                            input int rdly, input int sdly);
        logic cached;
        cached = (a < UNC);
        chk("st_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = wd; req_wmask = wm;
        tick();
        req_valid = 1'b0; req_write = 1'b0;
        for (int i = 0; i <= rdly; i++) begin
            chk("wr_req_valid", 64'(mem_req_valid), 64'd1);
            chk("wr_req_write", 64'(mem_req_write), 64'd1);
            chk("wr_req_addr", mem_req_addr, {a[63:3], 3'b000});
            chk("wr_req_wdata", mem_req_wdata, wd);
            chk("wr_req_wmask", 64'(mem_req_wmask), 64'(wm));
            chk("wr_wupd_valid", 64'(cache_wupd_valid), 64'((i == 0) && cached));
            chk("wr_no_upd", 64'(cache_upd_valid), 64'd0);
            if (i == 0 && cached) begin
                chk("wr_wupd_addr", cache_wupd_addr, a);
                chk("wr_wupd_data", cache_wupd_data, wd);
                chk("wr_wupd_mask", 64'(cache_wupd_mask), 64'(wm));
            end
            if (i == rdly) mem_req_ready = 1'b1;
            tick();
        end
        mem_req_ready = 1'b0;
        for (int i = 0; i < sdly; i++) begin
            chk("wr_wait_idle", 64'({mem_req_valid, resp_valid, cache_wupd_valid}), 64'd0);
            tick();
        end
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        chk("wr_resp_valid", 64'(resp_valid), 64'd1);
        chk("wr_resp_rdata", resp_rdata, 64'd0);
        chk("wr_resp_ready", 64'(req_ready), 64'd1);
        tick();
        chk("wr_after_quiet", 64'(resp_valid), 64'd0);
        chk_counters();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
        cache_hit = 1'b0; cache_rdata = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        exp_hits = '0; exp_miss = '0;
        #3;
        chk("rst_outputs", 64'({req_ready, resp_valid, mem_req_valid, cache_upd_valid,
                                cache_wupd_valid}), 64'd0);
        chk("rst_counters", {hit_count, miss_count}, 64'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_release_ready", 64'(req_ready), 64'd1);
        tick();

        // Build up some state, then reset asynchronously while in RD_WAIT.
        do_load(64'h8000_0100, 1'b1, 64'h0123_4567_89ab_cdef, 0, 0, '0);
        do_load(64'h8000_0200, 1'b0, '0, 1, 1, 64'h55aa_55aa_0000_1111);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h8000_0020; cache_hit = 1'b0;
        tick();
        req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_strobes", 64'({req_ready, resp_valid, mem_req_valid, cache_upd_valid,
                                   cache_wupd_valid}), 64'd0);
        chk("midrst_counters", {hit_count, miss_count}, 64'd0);
        chk("midrst_rdata", resp_rdata, 64'd0);
        chk("midrst_mem_addr", mem_req_addr, 64'd0);
        tick();
        rst = 1'b0;
        exp_hits = '0; exp_miss = '0;
        #1;
        chk("midrst_ready", 64'(req_ready), 64'd1);
        mem_resp_valid = 1'b1; mem_resp_rdata = 64'hbad0_bad0_bad0_bad0;
        tick();
        mem_resp_valid = 1'b0;
        chk("stale_resp_ignored", 64'({resp_valid, cache_upd_valid, mem_req_valid}), 64'd0);
        tick();
        chk("stale_resp_ignored2", 64'(resp_valid), 64'd0);
        chk_counters();

        // Directed cases.
        do_load(64'h8000_0010, 1'b1, 64'h1122_3344_5566_7788, 0, 0, '0);
        do_load(64'h8000_0014, 1'b0, '0, 3, 2, 64'h0000_0000_dead_beef);
        do_store(64'h8000_0008, 64'h0000_0000_0000_00ab, 8'h01, 0, 1);
        do_load(64'h0000_0000_a000_03f8, 1'b1, 64'hffff_0000_ffff_0000, 1, 1,
                64'h0c0c_0c0c_0c0c_0c0c);
        do_load(UNC - 64'd8, 1'b1, 64'h7777_6666_5555_4444, 0, 0, '0);
        do_load(UNC, 1'b0, '0, 0, 0, 64'h1357_9bdf_2468_ace0);
        do_store(UNC, 64'hfeed_face_cafe_f00d, 8'hf0, 2, 0);

        // Three back-to-back hits, one response per cycle.
        do_load(64'h8000_0040, 1'b1, 64'h1111_1111_1111_1111, 0, 0, '0);
        do_load(64'h8000_0048, 1'b1, 64'h2222_2222_2222_2222, 0, 0, '0);
        do_load(64'h8000_0050, 1'b1, 64'h3333_3333_3333_3333, 0, 0, '0);
        tick();
        chk("b2b_quiet", 64'(resp_valid), 64'd0);

        // Randomized mix.
        for (int n = 0; n < 40; n++) begin
            logic [63:0] a;
            int          k;
            k = int'($urandom_range(0, 3));
            if (k == 3) a = UNC + {32'h0, $urandom_range(0, 32'h0000_ffff)};
            else        a = 64'h8000_0000 + {32'h0, $urandom_range(0, 32'h0fff_ffff)};
            if ($urandom_range(0, 2) == 0)
                do_store(a, {$urandom, $urandom}, 8'($urandom_range(1, 255)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            else
                do_load(a, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                        {$urandom, $urandom});
        end

        // Counter wrap.
        force dut.hit_count = 32'hffff_ffff;
        #1;
        release dut.hit_count;
        exp_hits = 32'hffff_ffff;
        chk("wrap_preload", 64'(hit_count), 64'(exp_hits));
        do_load(64'h8000_0080, 1'b1, 64'h0f0f_0f0f_0f0f_0f0f, 0, 0, '0);
        chk("wrap_zero", 64'(hit_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ysyx_22041207_cache_refill.md
Name: ysyx_22041207_cache_refill

Overview:
Miss/refill and write-through controller between the core load/store port, the 2-way data cache and the memory bus. Load hits are returned from the cache. On a load miss it fetches the 8-byte word from memory, pulses the cache read-update port and returns the data. Stores invalidate the matching cache set and are written through to memory. Addresses at or above UNCACHED_BASE bypass the cache entirely.

Parameters:
UNCACHED_BASE, 64'h0000_0000_a000_0000, first address treated as uncached (MMIO); no hit use, no refill, no invalidate.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_valid  in  1  core request valid
req_ready  out  1  controller can accept a request (high only in IDLE)
req_write  in  1  1 = store, 0 = load
req_addr  in  64  byte address
req_wdata  in  64  store data
req_wmask  in  8  store byte mask
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  64  load data (0 for stores)
cache_raddr  out  64  cache lookup address; combinational = req_addr
cache_hit  in  1  cache hit for cache_raddr
cache_rdata  in  64  cache data for cache_raddr
cache_upd_valid  out  1  read-update pulse to cache
cache_upd_addr  out  64  refill address
cache_upd_data  out  64  refill data
cache_wupd_valid  out  1  store-invalidate pulse to cache
cache_wupd_addr  out  64  store address
cache_wupd_data  out  64  store data
cache_wupd_mask  out  8  store mask
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_write  out  1  memory request is a write
mem_req_addr  out  64  8-byte-aligned address ({addr[63:3],3'b0})
mem_req_wdata  out  64  write data
mem_req_wmask  out  8  write mask
mem_resp_valid  in  1  memory read data / write ack
mem_resp_rdata  in  64  memory read data
hit_count  out  32  cached load hits, wrapping
miss_count  out  32  cached load misses, wrapping

Behaviour:
- States: IDLE, RD_REQ, RD_WAIT, RD_DONE, WR_REQ, WR_WAIT.
- Reset (async, any state): state to IDLE. All registered outputs, mem_req_*, cache_*_valid, resp_*, and both counters go to 0. Any in-flight memory transaction is abandoned. req_ready is 1 once reset deasserts.
- Accept condition: req_valid && req_ready. The accepted request (address, data, mask, cached flag = addr < UNCACHED_BASE) is latched.
- Load, cached, cache_hit in the accept cycle: stay in IDLE. Next cycle: resp_valid=1, resp_rdata = latched cache_rdata, hit_count+1. The next request can be accepted in that same cycle. Latency is 1.
- Load, miss or uncached: go to RD_REQ. Cached misses increment miss_count.
- RD_REQ: mem_req_valid=1, mem_req_write=0, address held stable. Advance to RD_WAIT on mem_req_ready. Valid is never withdrawn before ready.
- RD_WAIT: wait for mem_resp_valid, latch mem_resp_rdata, go to RD_DONE.
- RD_DONE (1 cycle): resp_valid=1 with the data. If cached, also cache_upd_valid=1 with the aligned address and the data. Return to IDLE.
- Store accept: go to WR_REQ. In the first WR_REQ cycle only, cache_wupd_valid=1 with addr/data/mask; suppressed if uncached.
- WR_REQ: mem_req_valid=1, mem_req_write=1, wdata/wmask driven. Advance to WR_WAIT on mem_req_ready. If ready arrives in the first cycle, the invalidate pulse still occurs.
- WR_WAIT: on mem_resp_valid, go to IDLE with resp_valid=1 and resp_rdata=0.
- mem_resp_valid outside RD_WAIT/WR_WAIT is ignored, including stale responses after reset.
- cache_upd_valid and cache_wupd_valid are never high in the same cycle.
- Counters wrap from 0xFFFF_FFFF to 0.

Test Plan:
- Reset mid-RD_WAIT (rst pulse asynchronous to clk) -> all outputs 0 immediately. A later mem_resp_valid produces no resp_valid. req_ready=1 after reset release.
- Load 0x8000_0010 with cache_hit=1, cache_rdata=0x1122334455667788 -> resp_valid on the next cycle with that data. hit_count=1, no mem_req_valid.
- Load 0x8000_0014, miss; mem_req_ready delayed 3 cycles, response 0xDEADBEEF after 2 more -> mem_req_addr=0x8000_0010 held stable. In RD_DONE, cache_upd_valid=1 and resp_valid=1 in the same cycle, both with 0xDEADBEEF. miss_count=1.
- Store 0x8000_0008, wdata 0xAB, mask 0x01, mem_req_ready=1 immediately -> one cache_wupd_valid pulse, mem write with mask 0x01, then resp_valid (rdata 0) after the ack.
- Load 0xa000_03f8 (uncached) with cache_hit=1 -> hit ignored, memory read issued, no cache_upd_valid, counters unchanged.
- Back-to-back hits on 3 consecutive cycles -> 3 resp pulses one cycle apart. Preload hit_count=0xFFFFFFFF by forcing, then one hit -> hit_count wraps to 0.
